// File: rtl/jport_pkg.sv
// Shared types and widths for the jump/injection port host.
package jport_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/jport_host_if.sv
// Host-side handshake bundle: word injection in, captured result out.
interface jport_host_if;
  import jport_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_pc
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_pc
  );

endinterface

// File: rtl/jport_fifo.sv
// Synchronous word queue with registered count and full/empty flags.
// A push is only taken while not full, even if a pop happens in the same
// cycle, so the host never sees a word accepted into a full queue.
module jport_fifo
  import jport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic              full_r;
  logic              empty_r;
  logic              up_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // up_r keeps the queue closed while in reset and opens it on the first edge after
  assign push_ready = up_r & ~full_r;
  assign head       = mem_r[rd_ptr_r];
  assign empty      = empty_r;

  // Accepted push/pop strobes and the resulting occupancy
  always_comb begin
    push_ok_s = push & push_ready;
    pop_ok_s  = pop & ~empty_r;
    count_s   = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_s = count_r + CNT_ONE;
    end else if (!push_ok_s && pop_ok_s) begin
      count_s = count_r - CNT_ONE;
    end else begin
      count_s = count_r;
    end
  end

  // Pointers, count and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      up_r     <= 1'b0;
    end else begin
      up_r    <= 1'b1;
      count_r <= count_s;
      full_r  <= (count_s == CNT_MAX);
      empty_r <= (count_s == '0);
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/jport_host.sv
// Host for a core's jump/injection port: queues host words, drives each one
// to the core for a single cycle while the core is idle, waits (bounded) for
// InstDone, then captures Jout/pcOUT and holds it until the host takes it.
module jport_host
  import jport_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  jport_host_if.slave       host,
  output logic              Jen,
  output logic [DATA_W-1:0] Jin,
  input  logic [DATA_W-1:0] Jout,
  input  logic              InstDone,
  input  logic              nop,
  input  logic [PC_W-1:0]   pcOUT,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  state_t            state_r;
  state_t            state_s;
  logic              pop_s;
  logic              capture_s;
  logic              timeout_s;
  logic [DATA_W-1:0] head_s;
  logic              empty_s;
  logic [TW-1:0]     timer_r;
  logic              jen_r;
  logic [DATA_W-1:0] jin_r;
  logic              busy_r;
  logic              err_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [PC_W-1:0]   out_pc_r;

  jport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (host.in_valid),
    .push_data  (host.in_data),
    .push_ready (host.in_ready),
    .pop        (pop_s),
    .head       (head_s),
    .empty      (empty_s)
  );

  assign Jen            = jen_r;
  assign Jin            = jin_r;
  assign busy           = busy_r;
  assign err            = err_r;
  assign host.out_valid = out_valid_r;
  assign host.out_data  = out_data_r;
  assign host.out_pc    = out_pc_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next state and per-cycle strobes; InstDone beats the timeout in WAIT
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && nop) state_s = DRIVE;
        else                 state_s = IDLE;
      end
      DRIVE: begin
        pop_s   = 1'b1;
        state_s = WAIT;
      end
      WAIT: begin
        if (InstDone) begin
          capture_s = 1'b1;
          state_s   = HOLD;
        end else if (timer_r == T_MAX) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (out_valid_r && host.out_ready) state_s = IDLE;
        else                               state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Core-side drive registers: Jen for the DRIVE cycle, Jin held until back in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jen_r  <= 1'b0;
      jin_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      jen_r  <= (state_s == DRIVE);
      busy_r <= (state_s != IDLE);
      if ((state_r == IDLE) && (state_s == DRIVE)) jin_r <= head_s;
      else if (state_s == IDLE)                     jin_r <= '0;
    end
  end

  // Saturating wait timer, running only in WAIT and cleared elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else if (state_r == WAIT) begin
      if (timer_r != T_MAX) timer_r <= timer_r + T_ONE;
    end else begin
      timer_r <= '0;
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_r <= 1'b0;
    else if (timeout_s) err_r <= 1'b1;
    else if (err_clr)   err_r <= 1'b0;
  end

  // Result capture and hold until the host handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_pc_r    <= '0;
    end else begin
      if (capture_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= Jout;
        out_pc_r    <= pcOUT;
      end else if ((state_r == HOLD) && host.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jport_host.md
JPORT_HOST -- requirements
Module: jport_host

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the input-word queue depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles to wait for InstDone after a drive.
REQ-003 Clock and reset SHALL be one clock and one reset: clk in 1, rising-edge clock; rst in 1, asynchronous, active-high reset.
REQ-004 Port in_valid in 1 SHALL mean the host offers a jump/injection word.
REQ-005 Port in_ready out 1 SHALL mean the queue can accept a word this cycle.
REQ-006 Port in_data in 32 SHALL carry the offered word.
REQ-007 Port out_valid out 1 SHALL mean a captured result is available.
REQ-008 Port out_ready in 1 SHALL mean the host consumes the result this cycle.
REQ-009 Port out_data out 32 SHALL carry the captured Jout.
REQ-010 Port out_pc out 9 SHALL carry the pcOUT value captured with out_data.
REQ-011 Port Jen out 1 SHALL be the core's jump-enable strobe.
REQ-012 Port Jin out 32 SHALL be the core's jump/injection word.
REQ-013 Port Jout in 32 SHALL be the core's result word.
REQ-014 Port InstDone in 1 SHALL be the core's instruction-complete flag.
REQ-015 Port nop in 1 SHALL mean the core is idle.
REQ-016 Port pcOUT in 9 SHALL be the core's program counter.
REQ-017 Port busy out 1, err out 1 (sticky timeout), and err_clr in 1 SHALL be provided.

Function
REQ-018 The queue SHALL accept in_data on the edge where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when the queue is not full, and a push while full SHALL be refused even with a same-cycle pop.
REQ-019 The FSM SHALL have the states IDLE, DRIVE, WAIT and HOLD, with busy = (state != IDLE).
REQ-020 IDLE SHALL go to DRIVE when the queue is non-empty and nop = 1; otherwise it SHALL stay in IDLE.
REQ-021 DRIVE SHALL last exactly one cycle: Jen = 1, Jin = queue head, head popped on the exiting edge, timer cleared, then go to WAIT.
REQ-022 In WAIT, Jen SHALL be 0 and Jin SHALL hold the driven word; InstDone is sampled only in WAIT, and InstDone during DRIVE SHALL be ignored.
REQ-023 When InstDone = 1 in WAIT, the block SHALL register Jout into out_data and pcOUT into out_pc, set out_valid, and go to HOLD.
REQ-024 If the timer reaches TIMEOUT in WAIT without InstDone, the block SHALL set err, drop the word, and return to IDLE with no out_valid.
REQ-025 If InstDone and the timeout occur on the same cycle, InstDone SHALL win.
REQ-026 In HOLD, out_valid and out_data SHALL stay stable until out_valid & out_ready, then the FSM SHALL return to IDLE.
REQ-027 Minimum latency SHALL be: word accepted at edge e0 → DRIVE entered at e1 → Jen high for the cycle e1..e2; back-to-back words SHALL cost at least 4 cycles each.
REQ-028 Jin SHALL be 0 in IDLE.
REQ-029 err_clr SHALL clear err; if a timeout occurs on the same cycle as err_clr, the timeout SHALL win.
REQ-030 The timer SHALL be $clog2(TIMEOUT+1) bits wide and saturate, never wrapping.

Reset
REQ-031 While rst = 1: state = IDLE, queue empty, in_ready = 0, and out_valid, out_data, out_pc, Jen, Jin, busy, err and the timer all = 0.
REQ-032 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the transaction, with no out_valid after release; in_ready SHALL become 1 on the first edge after release.

Structure
REQ-033 Package jport_pkg SHALL hold the state enum, DATA_W = 32 and PC_W = 9.
REQ-034 The queue SHALL be a sub-module jport_fifo (synchronous, registered count, full/empty flags); the FSM and capture logic stay in jport_host.

Verification
REQ-035 Push 0x0000_0040 with nop = 1, InstDone pulsed 3 cycles after Jen, Jout = 0xDEAD_BEEF, pcOUT = 0x012 → Jen for one cycle with Jin = 0x40; out_data = 0xDEADBEEF, out_pc = 0x012.
REQ-036 Push 5 words with out_ready = 1 and InstDone never asserted → in_ready = 0 after 4 pushes; first Jen, then err = 1 at TIMEOUT+1 cycles in WAIT; no out_valid.
REQ-037 Hold out_ready = 0 for 10 cycles in HOLD while Jout changes → out_data stable, no new Jen until out_ready = 1.
REQ-038 Queue non-empty with nop = 0 for 20 cycles → Jen stays 0; it asserts the cycle after nop rises.
REQ-039 Assert rst in WAIT, then release, then pulse InstDone → no out_valid, queue empty, busy = 0.
REQ-040 InstDone asserted in DRIVE only → ignored; err after timeout.
